// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: serialises m0/m1 onto one slave with
// a one-cycle turnaround, round-robin or fixed-priority grant, and a stall watchdog.
module avalon_bus_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_WAIT       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_address,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  owner,
  output logic        timeout
);

  // State encodings double as the owner debug code.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_grant_r;
  logic [15:0] wait_cnt_r;
  logic [15:0] wait_cnt_inc_s;
  logic        timeout_r;
  logic        req0_s;
  logic        req1_s;
  logic        stalled_s;

  assign req0_s         = m0_read | m0_write;
  assign req1_s         = m1_read | m1_write;
  assign stalled_s      = (state_r != IDLE) && s_waitrequest;
  assign wait_cnt_inc_s = (wait_cnt_r == 16'hFFFF) ? wait_cnt_r : wait_cnt_r + 16'd1;
  assign owner          = state_r;
  assign timeout        = timeout_r;

  // Next-state: grant from IDLE, leave ownership on completion or request drop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0_s && req1_s) begin
          if (FIXED_PRIORITY != 0) begin
            state_nxt_s = OWN0;
          end else if (last_grant_r) begin
            state_nxt_s = OWN0;
          end else begin
            state_nxt_s = OWN1;
          end
        end else if (req0_s) begin
          state_nxt_s = OWN0;
        end else if (req1_s) begin
          state_nxt_s = OWN1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0: begin
        if (!req0_s || !s_waitrequest) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OWN0;
        end
      end
      OWN1: begin
        if (!req1_s || !s_waitrequest) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OWN1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Combinational routing of the owning master to the slave and back.
  always_comb begin
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_address      = 32'd0;
    s_writedata    = 32'd0;
    s_byteenable   = 4'd0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = 32'd0;
    m1_readdata    = 32'd0;
    case (state_r)
      OWN0: begin
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        s_address      = m0_address;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      OWN1: begin
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        s_address      = m1_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      default: begin
        s_read = 1'b0;
      end
    endcase
  end

  // State and round-robin history; last_grant starts at m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && state_nxt_s == OWN0) begin
        last_grant_r <= 1'b0;
      end else if (state_r == IDLE && state_nxt_s == OWN1) begin
        last_grant_r <= 1'b1;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Stall watchdog: the flag is sticky and never aborts the transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= 16'd0;
      timeout_r  <= 1'b0;
    end else begin
      if (state_nxt_s == IDLE) begin
        wait_cnt_r <= 16'd0;
      end else if (stalled_s) begin
        wait_cnt_r <= wait_cnt_inc_s;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (stalled_s && (wait_cnt_inc_s >= MAX_WAIT_C)) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter sharing the 8x8192 byte-addressed RAM between the CPU instruction-fetch port (m0) and data port (m1).
- Serialises accesses, routes readdata and waitrequest back to the owning master, and alternates grants round-robin or with fixed priority.
- A watchdog flags a slave that stalls too long.
- Sits between mips_cpu_bus master ports and RAM_8x8192_avalon_mapped.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin on contention; 1 = m0 always wins contention.
- MAX_WAIT, 64: max consecutive owner cycles with s_waitrequest=1 before the timeout flag sets. Range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_read, m0_write  in  1 each  master 0 command; held until m0_waitrequest=0.
- m0_address  in  32  master 0 byte address.
- m0_writedata  in  32  master 0 write data.
- m0_byteenable  in  4  master 0 byte lanes.
- m0_waitrequest  out  1  0 only in master 0's completing cycle.
- m0_readdata  out  32  valid when m0_waitrequest=0 during a read.
- m1_*  same set as m0_*, for master 1.
- s_read, s_write  out  1 each  slave command.
- s_address  out  32  slave address.
- s_writedata  out  32  slave write data.
- s_byteenable  out  4  slave byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data, valid in the cycle s_waitrequest=0.
- owner  out  2  0 = none, 1 = m0, 2 = m1 (debug).
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=m1 (so m0 wins the first tie), wait_cnt=0, timeout=0.
  - All s_* outputs=0, owner=0, m0/m1_waitrequest=1, m0/m1_readdata=0.
- Request definition: reqN = mN_read | mN_write. If both are high, write wins and read is masked to the slave.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - s_read=s_write=0, s_address/s_writedata/s_byteenable=0, both master waitrequests=1.
  - Next state on req0&!req1 -> OWN0; on req1&!req0 -> OWN1.
  - Both requesting: FIXED_PRIORITY=1 -> OWN0. FIXED_PRIORITY=0 -> the master not equal to last_grant.
  - No request: stay IDLE.
- OWNn:
  - s_* driven combinationally from master n.
  - mn_waitrequest = s_waitrequest; mn_readdata = s_readdata.
  - The non-owner sees waitrequest=1 and readdata=0.
  - last_grant updates to n on entry.
- Completion: in OWNn, a cycle with reqn=1 and s_waitrequest=0 completes the transfer; next state=IDLE.
  - Fixed 1-cycle turnaround: minimum 2 cycles per access with a zero-wait slave.
  - Back-to-back requests from the same master each pay the IDLE cycle.
- Abort: if reqn drops while in OWNn with s_waitrequest=1 (protocol violation), next state=IDLE. No completion is signalled.
- Watchdog:
  - wait_cnt increments each OWN cycle with s_waitrequest=1, saturating at 16 bits; clears on entry to IDLE.
  - When wait_cnt reaches MAX_WAIT, timeout sets to 1 and holds until reset. The transfer is not aborted.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). The owning master must reissue after reset.
- Data/address are not registered; latency from slave response to master response is 0 cycles.
- owner output is registered with the state.

Test Plan:
- Single read: m0_read=1, m0_address=0xBFC00000, s_waitrequest=0, s_readdata=0x8C020004.
  -> Cycle 1 IDLE; cycle 2 OWN0 with s_read=1, s_address=0xBFC00000, m0_waitrequest=0, m0_readdata=0x8C020004; cycle 3 IDLE.
- Contention, round-robin: both masters hold reads from reset, FIXED_PRIORITY=0.
  -> Grant order m0, m1, m0, m1. owner sequence 0,1,0,2,0,1. m1_waitrequest stays 1 throughout each m0 tenure.
- Contention, fixed priority: same stimulus with FIXED_PRIORITY=1.
  -> m0 is granted every time; m1 is never granted while m0 keeps requesting.
- Stalled write: m1_write=1, m1_writedata=0xDEADBEEF, m1_byteenable=4'b0011, s_waitrequest=1 for 3 cycles then 0.
  -> s_write and s_writedata are stable for 4 cycles; m1_waitrequest=0 only in the 4th; then IDLE.
- Watchdog: MAX_WAIT=4, s_waitrequest held at 1 during OWN0.
  -> timeout rises after the 4th stalled cycle and stays 1 after the transfer later completes.
- Reset mid-transfer: drive reset=0 asynchronously during OWN1 with s_waitrequest=1.
  -> s_write=0, owner=0, m1_waitrequest=1 before the next clock edge; after release, state=IDLE and timeout=0.
